// File: rtl/sym_pkg.sv
// Shared types and widths for the symbol-counting game round controller.
package sym_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW,
    ST_ENTRY,
    ST_ISSUE,
    ST_RESP,
    ST_OVER,
    ST_WON
  } seq_state_t;

  localparam int DIFF_W  = 5;
  localparam int LEVEL_W = 4;
  localparam int TIMER_W = 32;

  function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                  input logic [DIFF_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Up-counting phase timer with synchronous clear and a terminal-count flag.
module phase_timer
  import sym_pkg::*;
(
  input  logic               Clk100M,
  input  logic               Rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] limit,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  // Clear wins over counting so a phase change always restarts from zero.
  always_ff @(posedge Clk100M or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign done = enable && (count == limit);

endmodule

// File: rtl/level_sequencer.sv
// Round controller: show phase, timed entry phase, judge request, verdict handling.
module level_sequencer
  import sym_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES  = 200_000_000,
  parameter int unsigned ENTRY_CYCLES = 500_000_000,
  parameter int unsigned MAX_LEVEL    = 15
) (
  input  logic               Clk100M,
  input  logic               Rst,
  input  logic               start,
  input  logic               userPress,
  input  logic               submit,
  input  logic [DIFF_W-1:0]  targetCount,
  input  logic               incLevel,
  input  logic               lose,
  output logic               levelComplete,
  output logic [DIFF_W-1:0]  difference,
  output logic [LEVEL_W-1:0] level,
  output logic [DIFF_W-1:0]  userCount,
  output logic               showActive,
  output logic               entryActive,
  output logic               gameOver,
  output logic               gameWon,
  output seq_state_t         dbgState
);

  // Handshake: levelComplete is a one-cycle valid for difference with no ready;
  // the judge captures at the closing edge, and its incLevel/lose verdict is
  // accepted only in RESP, which waits as long as needed for one to arrive.

  localparam logic [TIMER_W-1:0] SHOW_LIM  = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ENTRY_LIM = TIMER_W'(ENTRY_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LAST_LVL  = LEVEL_W'(MAX_LEVEL);

  seq_state_t         state, state_nxt;
  logic               tmr_done, entry_end;
  logic [DIFF_W-1:0]  count_inc;
  logic               show_d, entry_d, issue_d, over_d, won_d;

  phase_timer u_timer (
    .Clk100M (Clk100M),
    .Rst     (Rst),
    .clear   (state_nxt != state),
    .enable  ((state == ST_SHOW) || (state == ST_ENTRY)),
    .limit   ((state == ST_SHOW) ? SHOW_LIM : ENTRY_LIM),
    .done    (tmr_done)
  );

  assign entry_end = submit || tmr_done;
  assign count_inc = (userPress && (userCount != {DIFF_W{1'b1}})) ? userCount + 1'b1 : userCount;
  assign dbgState  = state;

  always_ff @(posedge Clk100M or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_OVER, ST_WON: if (start) state_nxt = ST_SHOW;
      ST_SHOW:  if (tmr_done) state_nxt = ST_ENTRY;
      ST_ENTRY: if (entry_end) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP: begin
        if (lose)                         state_nxt = ST_OVER;
        else if (incLevel && level == LAST_LVL) state_nxt = ST_WON;
        else if (incLevel)                state_nxt = ST_SHOW;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Flags are decoded from the next state so they line up with the state register.
  always_comb begin
    show_d  = (state_nxt == ST_SHOW);
    entry_d = (state_nxt == ST_ENTRY);
    issue_d = (state_nxt == ST_ISSUE);
    over_d  = (state_nxt == ST_OVER);
    won_d   = (state_nxt == ST_WON);
  end

  always_ff @(posedge Clk100M or posedge Rst) begin
    if (Rst) begin
      showActive    <= 1'b0;
      entryActive   <= 1'b0;
      levelComplete <= 1'b0;
      gameOver      <= 1'b0;
      gameWon       <= 1'b0;
    end else begin
      showActive    <= show_d;
      entryActive   <= entry_d;
      levelComplete <= issue_d;
      gameOver      <= over_d;
      gameWon       <= won_d;
    end
  end

  always_ff @(posedge Clk100M or posedge Rst) begin
    if (Rst) begin
      level      <= '0;
      userCount  <= '0;
      difference <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER, ST_WON: begin
          if (start) begin
            level     <= '0;
            userCount <= '0;
          end
        end
        ST_ENTRY: begin
          userCount <= count_inc;
          if (entry_end) difference <= abs_diff(count_inc, targetCount);
        end
        ST_RESP: begin
          if (!lose && incLevel && level != LAST_LVL) begin
            level     <= level + 1'b1;
            userCount <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with short phase lengths.
module tb_level_sequencer;
  import sym_pkg::*;

  logic Clk100M;
  logic Rst;

  logic       start, userPress, submit, incLevel, lose;
  logic [4:0] targetCount;
  logic       levelComplete, showActive, entryActive, gameOver, gameWon;
  logic [4:0] difference, userCount;
  logic [3:0] level;
  seq_state_t dbgState;

  logic       start_b, userPress_b, submit_b, incLevel_b, lose_b;
  logic [4:0] targetCount_b;
  logic       levelComplete_b, showActive_b, entryActive_b, gameOver_b, gameWon_b;
  logic [4:0] difference_b, userCount_b;
  logic [3:0] level_b;
  seq_state_t dbgState_b;

  int n_cmp = 0;
  int n_err = 0;

  level_sequencer #(.SHOW_CYCLES(4), .ENTRY_CYCLES(10), .MAX_LEVEL(15)) dut (
    .Clk100M(Clk100M), .Rst(Rst), .start(start), .userPress(userPress),
    .submit(submit), .targetCount(targetCount), .incLevel(incLevel), .lose(lose),
    .levelComplete(levelComplete), .difference(difference), .level(level),
    .userCount(userCount), .showActive(showActive), .entryActive(entryActive),
    .gameOver(gameOver), .gameWon(gameWon), .dbgState(dbgState)
  );

  level_sequencer #(.SHOW_CYCLES(2), .ENTRY_CYCLES(64), .MAX_LEVEL(15)) dut_b (
    .Clk100M(Clk100M), .Rst(Rst), .start(start_b), .userPress(userPress_b),
    .submit(submit_b), .targetCount(targetCount_b), .incLevel(incLevel_b), .lose(lose_b),
    .levelComplete(levelComplete_b), .difference(difference_b), .level(level_b),
    .userCount(userCount_b), .showActive(showActive_b), .entryActive(entryActive_b),
    .gameOver(gameOver_b), .gameWon(gameWon_b), .dbgState(dbgState_b)
  );

  initial Clk100M = 1'b0;
  always #5 Clk100M = ~Clk100M;

  task automatic tick();
    @(posedge Clk100M);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for ENTRY, presses, submits, and returns one cycle after the request (in RESP).
  task automatic run_level(input int presses, input logic [4:0] tgt);
    int guard;
    guard = 0;
    while (!entryActive && guard < 100) begin
      tick();
      guard++;
    end
    check("entry_reached", 32'(entryActive), 32'd1);
    targetCount = tgt;
    for (int i = 0; i < presses; i++) begin
      userPress = 1'b1;
      tick();
    end
    userPress = 1'b0;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    check("lvl_request", 32'(levelComplete), 32'd1);
    tick();
    check("lvl_single_pulse", 32'(levelComplete), 32'd0);
  endtask

  initial begin
    int cnt;
    int p;
    int t;
    int exp_diff;

    Rst = 1'b1;
    start = 0; userPress = 0; submit = 0; incLevel = 0; lose = 0; targetCount = '0;
    start_b = 0; userPress_b = 0; submit_b = 0; incLevel_b = 0; lose_b = 0; targetCount_b = '0;
    tick();
    tick();
    check("rst_outputs", 32'({levelComplete, difference, level, userCount,
                              showActive, entryActive, gameOver, gameWon}), 32'd0);
    check("rst_state", 32'(dbgState), 32'(ST_IDLE));
    Rst = 1'b0;
    tick();

    // Level 0: timer-expiry end, 6 presses vs target 8.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_show", 32'(showActive), 32'd1);
    check("start_state", 32'(dbgState), 32'(ST_SHOW));
    cnt = 0;
    while (showActive && cnt < 50) begin
      cnt++;
      tick();
    end
    check("show_len", 32'(cnt), 32'd4);
    check("entry_after_show", 32'(entryActive), 32'd1);
    targetCount = 5'd8;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      userPress = 1'b1;
      tick();
      cnt++;
    end
    userPress = 1'b0;
    check("count_6", 32'(userCount), 32'd6);
    while (!levelComplete && cnt < 50) begin
      tick();
      cnt++;
    end
    check("entry_len", 32'(cnt), 32'd10);
    check("diff_expiry", 32'(difference), 32'd2);
    tick();
    check("pulse_end", 32'(levelComplete), 32'd0);
    check("resp_state", 32'(dbgState), 32'(ST_RESP));
    incLevel = 1'b1;
    tick();
    incLevel = 1'b0;
    check("adv_level", 32'(level), 32'd1);
    check("adv_show", 32'(showActive), 32'd1);
    check("adv_count_clr", 32'(userCount), 32'd0);

    // Level 1: lose held high throughout; press and submit in the same cycle.
    lose = 1'b1;
    tick();
    check("lose_ignored_show", 32'(gameOver), 32'd0);
    cnt = 0;
    while (!entryActive && cnt < 50) begin
      tick();
      cnt++;
    end
    check("lose_ignored_entry", 32'(entryActive), 32'd1);
    targetCount = 5'd1;
    for (int i = 0; i < 3; i++) begin
      userPress = 1'b1;
      tick();
    end
    userPress = 1'b1;
    submit = 1'b1;
    tick();
    userPress = 1'b0;
    submit = 1'b0;
    check("sub_request", 32'(levelComplete), 32'd1);
    check("sub_diff", 32'(difference), 32'd3);
    check("sub_count", 32'(userCount), 32'd4);
    tick();
    check("sub_single", 32'(levelComplete), 32'd0);
    check("lose_ignored_issue", 32'(gameOver), 32'd0);
    tick();
    check("lose_over", 32'(gameOver), 32'd1);
    check("lose_no_req", 32'(levelComplete), 32'd0);

    // Restart from OVER, then play through every level to a win.
    start = 1'b1;
    tick();
    start = 1'b0;
    lose = 1'b0;
    check("restart_level", 32'(level), 32'd0);
    check("restart_show", 32'(showActive), 32'd1);
    check("restart_over_clr", 32'(gameOver), 32'd0);
    for (int lv = 0; lv < 16; lv++) begin
      p = (lv * 3) % 10;
      t = lv + 2;
      exp_diff = (p >= t) ? p - t : t - p;
      run_level(p, 5'(t));
      check("loop_diff", 32'(difference), 32'(exp_diff));
      check("loop_count", 32'(userCount), 32'(p));
      incLevel = 1'b1;
      tick();
      incLevel = 1'b0;
      if (lv < 15) begin
        check("loop_level", 32'(level), 32'(lv + 1));
        check("loop_show", 32'(showActive), 32'd1);
        check("loop_count_clr", 32'(userCount), 32'd0);
      end else begin
        check("win_flag", 32'(gameWon), 32'd1);
        check("win_level", 32'(level), 32'd15);
        check("win_no_show", 32'(showActive), 32'd0);
      end
    end

    // Restart from WON, then reset asynchronously mid-ENTRY with 7 presses.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_won_clr", 32'(gameWon), 32'd0);
    cnt = 0;
    while (!entryActive && cnt < 50) begin
      tick();
      cnt++;
    end
    for (int i = 0; i < 7; i++) begin
      userPress = 1'b1;
      tick();
    end
    userPress = 1'b0;
    check("pre_rst_count", 32'(userCount), 32'd7);
    check("pre_rst_state", 32'(dbgState), 32'(ST_ENTRY));
    Rst = 1'b1;
    #2;
    check("async_rst_outputs", 32'({levelComplete, difference, level, userCount,
                                    showActive, entryActive, gameOver, gameWon}), 32'd0);
    check("async_rst_state", 32'(dbgState), 32'(ST_IDLE));
    tick();
    Rst = 1'b0;
    tick();

    // Long-entry instance: 40 presses saturate the counter.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cnt = 0;
    while (!entryActive_b && cnt < 50) begin
      tick();
      cnt++;
    end
    check("b_entry", 32'(entryActive_b), 32'd1);
    targetCount_b = 5'd0;
    for (int i = 0; i < 40; i++) begin
      userPress_b = 1'b1;
      tick();
    end
    userPress_b = 1'b0;
    check("sat_count", 32'(userCount_b), 32'd31);
    submit_b = 1'b1;
    tick();
    submit_b = 1'b0;
    check("sat_request", 32'(levelComplete_b), 32'd1);
    check("sat_diff", 32'(difference_b), 32'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Round controller for the symbol-counting game and the issuing side of the level-judging handshake. It runs each level through three phases: a symbol show phase, a timed user-entry phase, and a judge request. The request is a one-cycle `levelComplete` pulse carrying the absolute count `difference`. The block then consumes the judge's `incLevel` / `lose` verdict to advance the level, end the game, or declare a win.

## Interface
Parameters:
- `SHOW_CYCLES`, default 200_000_000: length of the show phase in clock cycles (2 s at 100 MHz); must be ≥ 1.
- `ENTRY_CYCLES`, default 500_000_000: length of the entry window in cycles (5 s); must be ≥ 1.
- `MAX_LEVEL`, default 15: index of the last level; passing it wins the game.

Ports:
- `Clk100M` in 1: 100 MHz system clock; one clock domain only.
- `Rst` in 1: reset; asynchronous and active-high.
- `start` in 1: single-cycle pulse; begins a game from IDLE, OVER or WON.
- `userPress` in 1: debounced single-cycle press pulse, counted during ENTRY only.
- `submit` in 1: single-cycle pulse; ends ENTRY early.
- `targetCount` in 5: true symbol count for the current level, from the symbol generator; sampled at the end of ENTRY.
- `incLevel` in 1: judge verdict "pass".
- `lose` in 1: judge verdict "fail"; may be sticky high outside RESP.
- `levelComplete` out 1: one-cycle judge request pulse.
- `difference` out 5: |userCount − targetCount|, valid while `levelComplete` = 1 and held until the next request.
- `level` out 4: current level index.
- `userCount` out 5: presses counted in the current level.
- `showActive` out 1: high in SHOW.
- `entryActive` out 1: high in ENTRY.
- `gameOver` out 1: high in OVER.
- `gameWon` out 1: high in WON.

## Operation
- States: IDLE, SHOW, ENTRY, ISSUE, RESP, OVER, WON. Reset and idle state is IDLE.
- IDLE/OVER/WON, on `start`: `level`←0, `userCount`←0, timer cleared, go to SHOW.
- SHOW: timer counts up. When it reaches SHOW_CYCLES−1, clear the timer and go to ENTRY.
- ENTRY:
  - `userPress` increments `userCount`, saturating at 31.
  - End condition: `submit`, or timer = ENTRY_CYCLES−1. On the end condition, register `difference` and set `levelComplete`←1, then go to ISSUE.
  - A press in the same cycle as the end condition is counted. The `difference` uses the post-increment count.
- ISSUE: `levelComplete` = 1 for exactly this cycle. The judge registers its verdict at the closing edge. Go to RESP.
- RESP: wait for the verdict.
  - `lose` = 1 → OVER. `lose` has priority if both inputs are high.
  - `incLevel` = 1 with `level` = MAX_LEVEL → WON.
  - `incLevel` = 1 otherwise → `level`+1, `userCount`←0, go to SHOW.
  - Neither input high → stay in RESP.
- Arithmetic: `difference` = (u ≥ t) ? u−t : t−u, computed on 5-bit unsigned values; no wrap is possible. The timer is 32-bit unsigned.
- `start`, `userPress` and `submit` are ignored outside the states listed above.
- `incLevel` and `lose` are ignored outside RESP, so a stale sticky `lose` has no effect.

## Timing
- Reset values: `levelComplete`, `difference`, `level`, `userCount`, `showActive`, `entryActive`, `gameOver` and `gameWon` are all 0. The state is IDLE and the timer is 0.
- Reset asserted mid-operation returns the block to IDLE immediately, asynchronously, and aborts any pending request.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Phase lengths:
  - `start` at edge n → `showActive` high from cycle n+1, for exactly SHOW_CYCLES cycles.
  - ENTRY lasts at most ENTRY_CYCLES cycles.
- End of ENTRY at edge m → `levelComplete` high during cycle m+1 only. The verdict is sampled from cycle m+2 onward.
- Minimum turnaround: verdict seen at edge k → SHOW, OVER or WON from cycle k+1.
- `submit` and timer expiry in the same cycle produce a single request.

## Structure
- Package `sym_pkg`: state enum `seq_state_t`, `DIFF_W` = 5, `LEVEL_W` = 4, `TIMER_W` = 32.
- One sub-module `phase_timer` (clear, enable, terminal-count compare), shared by SHOW and ENTRY with the limit selected by state.
- The FSM, press counter and difference register stay in `level_sequencer`.

## Test plan
- Reset mid-ENTRY with `userCount` = 7: all outputs 0 and state IDLE immediately, before the next clock edge.
- SHOW_CYCLES = 4, ENTRY_CYCLES = 10, `start`, 6 presses, `targetCount` = 8, no `submit`: `levelComplete` is one pulse exactly 10 ENTRY cycles after SHOW ends, with `difference` = 2.
- ENTRY with 3 presses, then `userPress` and `submit` in the same cycle, `targetCount` = 1: `difference` = 3, one request only.
- 40 presses with `targetCount` = 0: `userCount` saturates at 31 and `difference` = 31.
- RESP driven with `incLevel` at `level` = 3 → `level` = 4, SHOW re-entered, `userCount` = 0. At `level` = MAX_LEVEL → `gameWon` = 1. With `lose` = 1 → `gameOver` = 1. With `lose` held high through a whole level → ignored until RESP.
- `start` in OVER → `level` = 0, SHOW, `gameOver` = 0 the next cycle.
